// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int LINES_DEF          = 64;
  localparam int WORDS_PER_LINE_DEF = 4;
  localparam int ADDR_W             = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    WDONE = 2'd3
  } state_t;

  function automatic int word_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  // Tag is whatever is left above byte offset, word select and index.
  function automatic int tag_bits(input int lines, input int words_per_line);
    return ADDR_W - 2 - $clog2(lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/data_cache_ctrl_if.sv
// Main-memory port of the data cache: the cache is master, the memory is slave.
interface data_cache_ctrl_if;
  // Handshake: master raises memReq with memWe/memAddr/memWData and holds all four
  // constant until the slave returns a one-cycle memAck (allowed in the very cycle
  // memReq first rises, never while memReq is low); memRData is valid only with memAck.
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memAck;

  modport master (
    output memReq, memWe, memAddr, memWData,
    input  memRData, memAck
  );

  modport slave (
    input  memReq, memWe, memAddr, memWData,
    output memRData, memAck
  );
endinterface

// File: rtl/dcache_line_store.sv
// Tag/valid/data arrays of the cache: combinational lookup, one synchronous write port.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter  int LINES          = LINES_DEF,
  parameter  int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  localparam int WORD_W         = word_bits(WORDS_PER_LINE),
  localparam int INDEX_W        = index_bits(LINES),
  localparam int TAG_W          = tag_bits(LINES, WORDS_PER_LINE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [WORD_W-1:0]  rd_word,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               hit,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic [31:0]        wr_data,
  input  logic               wr_set_line,
  input  logic [TAG_W-1:0]   wr_tag
);

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS_PER_LINE];
  logic [LINES-1:0] valid;

  assign hit     = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
  assign rd_data = data_mem[{rd_index, rd_word}];

  // Only the valid bits are reset; stale tags/data are harmless behind a clear valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en && wr_set_line) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_index, wr_word}] <= wr_data;
    end
    if (wr_en && wr_set_line) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for a
// single-cycle core: stalls on read misses and on every store.
module data_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES          = LINES_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic [31:0]        addr,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               stall,
  data_cache_ctrl_if.master  mem,
  output state_t             dbg_state
);

  localparam int WORD_W    = word_bits(WORDS_PER_LINE);
  localparam int INDEX_W   = index_bits(LINES);
  localparam int TAG_W     = tag_bits(LINES, WORDS_PER_LINE);
  localparam int INDEX_LSB = 2 + WORD_W;
  localparam int TAG_LSB   = INDEX_LSB + INDEX_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

  logic [WORD_W-1:0]  a_word;
  logic [INDEX_W-1:0] a_index;
  logic [TAG_W-1:0]   a_tag;
  logic               unused_byte_offset;

  assign a_word             = addr[INDEX_LSB-1:2];
  assign a_index            = addr[TAG_LSB-1:INDEX_LSB];
  assign a_tag              = addr[31:TAG_LSB];
  assign unused_byte_offset = ^addr[1:0];

  state_t            state, state_n;
  logic [WORD_W-1:0] cnt, cnt_n, cnt_inc;
  logic              req_q, req_n;
  logic              we_q, we_n;
  logic [31:0]       maddr_q, maddr_n;
  logic [31:0]       wdata_q, wdata_n;

  logic              hit;
  logic [31:0]       hit_data;
  logic              st_we;
  logic [WORD_W-1:0] st_word;
  logic [31:0]       st_data;
  logic              st_set;

  assign cnt_inc = cnt + WORD_W'(1);

  dcache_line_store #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .rd_index    (a_index),
    .rd_word     (a_word),
    .rd_tag      (a_tag),
    .hit         (hit),
    .rd_data     (hit_data),
    .wr_en       (st_we && !rst),
    .wr_index    (a_index),
    .wr_word     (st_word),
    .wr_data     (st_data),
    .wr_set_line (st_set),
    .wr_tag      (a_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      req_q   <= req_n;
      we_q    <= we_n;
      maddr_q <= maddr_n;
      wdata_q <= wdata_n;
    end
  end

  // The core holds addr/writeData stable while stalled, so index/tag/word can be
  // taken straight from addr in every state.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    req_n    = req_q;
    we_n     = we_q;
    maddr_n  = maddr_q;
    wdata_n  = wdata_q;
    stall    = 1'b0;
    readData = 32'h0;
    st_we    = 1'b0;
    st_word  = a_word;
    st_data  = writeData;
    st_set   = 1'b0;

    case (state)
      IDLE: begin
        if (memWrite) begin
          stall   = 1'b1;
          state_n = WRITE;
          req_n   = 1'b1;
          we_n    = 1'b1;
          maddr_n = {addr[31:2], 2'b00};
          wdata_n = writeData;
        end else if (memRead && !hit) begin
          stall   = 1'b1;
          state_n = FILL;
          cnt_n   = '0;
          req_n   = 1'b1;
          we_n    = 1'b0;
          maddr_n = {a_tag, a_index, {WORD_W{1'b0}}, 2'b00};
        end else if (memRead) begin
          readData = hit_data;
        end
      end

      FILL: begin
        stall = 1'b1;
        if (mem.memAck) begin
          st_we   = 1'b1;
          st_word = cnt;
          st_data = mem.memRData;
          if (cnt == LAST_WORD) begin
            st_set  = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
            req_n   = 1'b0;
          end else begin
            cnt_n   = cnt_inc;
            maddr_n = {a_tag, a_index, cnt_inc, 2'b00};
          end
        end
      end

      WRITE: begin
        stall = 1'b1;
        if (mem.memAck) begin
          // Write-through: refresh the cached copy only on a hit, never allocate.
          st_we   = hit;
          state_n = WDONE;
          req_n   = 1'b0;
          we_n    = 1'b0;
        end
      end

      WDONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign mem.memReq   = req_q;
  assign mem.memWe    = we_q;
  assign mem.memAddr  = maddr_q;
  assign mem.memWData = wdata_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed plus randomized bench for data_cache_ctrl with a line-level reference
// model and a request-ordered expected queue for the memory port.
module tb_data_cache_ctrl;
  import dcache_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite;
  logic [31:0] addr, writeData, readData;
  logic        stall;
  state_t      dbg_state;

  data_cache_ctrl_if mif ();

  data_cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .addr      (addr),
    .writeData (writeData),
    .readData  (readData),
    .stall     (stall),
    .mem       (mif),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  // {we, word-aligned address, write data}; read entries ignore the data field
  logic [64:0] exp_q[$];

  // reference model: backing memory contents as the core sees them, plus line tags
  logic [31:0] ref_mem [logic [29:0]];
  bit          ref_vld [64];
  logic [21:0] ref_tag [64];

  // memory slave
  logic [31:0] mem_arr [logic [29:0]];
  int          fixed_lat  = 1;
  bit          rand_lat   = 1'b0;
  int          ack_cnt    = 0;
  int          ack_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] default_word(input logic [29:0] wa);
    return {wa, 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return default_word(a[31:2]);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a[31:2])) return mem_arr[a[31:2]];
    return default_word(a[31:2]);
  endfunction

  // ---------------- memory slave / request checker ----------------
  initial begin : mem_slave
    bit          busy;
    int          wait_cnt;
    logic [64:0] cur;
    logic [64:0] e;
    busy         = 1'b0;
    wait_cnt     = 0;
    mif.memAck   = 1'b0;
    mif.memRData = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mif.memAck = 1'b0;
      if (!mif.memReq) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy       = 1'b1;
          cur        = {mif.memWe, mif.memAddr, mif.memWData};
          wait_cnt   = rand_lat ? int'($urandom_range(0, 2)) : fixed_lat;
          ack_cycles += wait_cnt + 1;
          check("req_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("req_we", 32'(cur[64]), 32'(e[64]));
            check("req_addr", cur[63:32], e[63:32]);
            if (e[64]) check("req_wdata", cur[31:0], e[31:0]);
          end
        end else begin
          check("req_addr_stable", mif.memAddr, cur[63:32]);
          check("req_we_stable", 32'(mif.memWe), 32'(cur[64]));
        end
        if (wait_cnt == 0) begin
          mif.memAck = 1'b1;
          if (mif.memWe) mem_arr[mif.memAddr[31:2]] = mif.memWData;
          else           mif.memRData = mem_rd(mif.memAddr);
          busy = 1'b0;
          ack_cnt++;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [31:0] a);
    int          idx;
    logic [21:0] tg;
    bit          exp_hit;
    logic [31:0] expd;
    int          cyc;
    idx     = int'(a[9:4]);
    tg      = a[31:10];
    exp_hit = ref_vld[idx] && (ref_tag[idx] == tg);
    expd    = ref_rd(a);
    if (!exp_hit) begin
      for (int w = 0; w < 4; w++) begin
        exp_q.push_back({1'b0, a[31:4], 2'(w), 2'b00, 32'h0});
      end
    end
    ack_cycles = 0;
    @(negedge clk);
    memRead   = 1'b1;
    memWrite  = 1'b0;
    addr      = a;
    writeData = $urandom;
    #1;
    cyc = 0;
    while (stall && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check("load_stall_cycles", 32'(cyc), exp_hit ? 32'd0 : 32'(1 + ack_cycles));
    check("load_data", readData, expd);
    check("load_memreq_low", 32'(mif.memReq), 32'd0);
    check("load_reqs_consumed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    ref_vld[idx] = 1'b1;
    ref_tag[idx] = tg;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit both);
    int cyc;
    exp_q.push_back({1'b1, a[31:2], 2'b00, d});
    ack_cycles = 0;
    @(negedge clk);
    memRead   = both;
    memWrite  = 1'b1;
    addr      = a;
    writeData = d;
    #1;
    check("store_idle_stall", 32'(stall), 32'd1);
    cyc = 0;
    while (stall && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check("store_stall_cycles", 32'(cyc), 32'(1 + ack_cycles));
    check("store_wdone_state", 32'(dbg_state), 32'(WDONE));
    check("store_memreq_low", 32'(mif.memReq), 32'd0);
    check("store_reqs_consumed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    ref_mem[a[31:2]] = d;
  endtask

  task automatic do_idle();
    @(negedge clk);
    memRead  = 1'b0;
    memWrite = 1'b0;
    #1;
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_readdata", readData, 32'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int          cyc;
    logic [31:0] a;
    int          op;
    rst       = 1'b1;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    addr      = 32'h0;
    writeData = 32'h0;
    for (int i = 0; i < 64; i++) ref_vld[i] = 1'b0;
    for (int w = 0; w < 4; w++) begin
      mem_arr[30'h40 + 30'(w)] = 32'hA0 + 32'(w);
      ref_mem[30'h40 + 30'(w)] = 32'hA0 + 32'(w);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_memreq", 32'(mif.memReq), 32'd0);
    check("rst_memwe", 32'(mif.memWe), 32'd0);
    check("rst_memaddr", mif.memAddr, 32'h0);
    check("rst_memwdata", mif.memWData, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_readdata", readData, 32'h0);

    // cold miss, hit, store hit, store miss, conflict eviction
    fixed_lat = 1;
    do_load(32'h100);
    check("cold_miss_data", readData, 32'hA0);
    do_load(32'h108);
    check("hit_data_a2", readData, 32'hA2);
    do_store(32'h104, 32'hDEADBEEF, 1'b0);
    do_load(32'h104);
    check("store_hit_reload", readData, 32'hDEADBEEF);
    do_idle();
    do_store(32'h2000, 32'h1234_5678, 1'b0);
    do_load(32'h100);
    do_load(32'h2000);
    check("store_miss_reload", readData, 32'h1234_5678);
    do_load(32'h500);
    do_load(32'h100);
    fixed_lat = 0;
    do_load(32'h10C);
    do_store(32'h108, 32'hCAFE_F00D, 1'b1);
    do_idle();

    // reset during a refill, right at the second ack
    fixed_lat = 1;
    exp_q.delete();
    for (int w = 0; w < 4; w++) exp_q.push_back({1'b0, 28'h000_0304, 2'(w), 2'b00, 32'h0});
    ack_cnt = 0;
    @(negedge clk);
    memRead  = 1'b1;
    memWrite = 1'b0;
    addr     = 32'h3040;
    cyc      = 0;
    while (ack_cnt < 2 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("rst_fill_acks", 32'(ack_cnt), 32'd2);
    rst     = 1'b1;
    memRead = 1'b0;
    @(negedge clk);
    #1;
    check("rst_fill_memreq", 32'(mif.memReq), 32'd0);
    check("rst_fill_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) ref_vld[i] = 1'b0;
    do_load(32'h3040);
    do_load(32'h3048);
    do_load(32'h100);

    // randomized traffic over a few conflicting lines with random ack latency
    rand_lat = 1'b1;
    for (int n = 0; n < 60; n++) begin
      a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3) * 5) << 4) |
           (32'($urandom_range(0, 3)) << 2);
      op = int'($urandom_range(0, 3));
      if (op == 0 || op == 1) do_load(a);
      else if (op == 2)       do_store(a, $urandom, 1'b0);
      else                    do_store(a, $urandom, 1'b1);
      if ($urandom_range(0, 4) == 0) do_idle();
    end
    do_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
